// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and byte-address to word-index conversion.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Drops the byte-lane bits of a byte address; data_w is 32 or 64.
    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr, input int unsigned data_w);
        return (data_w == 64) ? (addr >> 3) : (addr >> 2);
    endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Combinational byte-enable merge: each byte comes from new_i when its strobe is set, else old_i.
module axil_wstrb_merge #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] strb_i,
    output logic [DATA_W-1:0]   merged_o
);

    for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
        assign merged_o[b*8 +: 8] = strb_i[b] ? new_i[b*8 +: 8] : old_i[b*8 +: 8];
    end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: N_CTRL read/write control words followed by N_STAT read-only status words.
// Build option: define AXIL_REG_BANK_SLVERR_EN to answer stat writes and out-of-range accesses with SLVERR.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned N_CTRL = 8,
    parameter int unsigned N_STAT = 8,
    parameter logic [N_CTRL*DATA_W-1:0] CTRL_RST = '0
) (
    input  logic                       Clk,
    input  logic                       reset_rtl_0,
    input  logic [ADDR_W-1:0]          s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [DATA_W-1:0]          s_axil_wdata,
    input  logic [DATA_W/8-1:0]        s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_W-1:0]          s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [DATA_W-1:0]          s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [N_CTRL*DATA_W-1:0]   ctrl_o,
    output logic [N_CTRL-1:0]          ctrl_wr_o,
    // Kept one word wide when N_STAT is 0 so the port never collapses to zero width.
    input  logic [(N_STAT > 0 ? N_STAT : 1)*DATA_W-1:0] stat_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CIDX_W = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam int unsigned N_REGS = N_CTRL + N_STAT;

    logic                aw_full_q, aw_full_d;
    logic                aw_is_ctrl_q, aw_is_ctrl_d;
    logic [CIDX_W-1:0]   aw_sel_q, aw_sel_d;
    logic                w_full_q, w_full_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]   w_strb_q, w_strb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   ctrl_q [N_CTRL];
    logic [DATA_W-1:0]   ctrl_d [N_CTRL];
    logic [N_CTRL-1:0]   ctrl_wr_q, ctrl_wr_d;

    logic [63:0]         aw_idx, ar_idx;
    logic [DATA_W-1:0]   old_word, merged_word, rd_word;
    logic [1:0]          wr_resp, rd_resp;
    logic                aw_hs, w_hs, ar_hs, commit;
    logic                unused_prot;

    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    assign aw_hs  = s_axil_awvalid && !aw_full_q;
    assign w_hs   = s_axil_wvalid && !w_full_q;
    assign ar_hs  = s_axil_arvalid && !rvalid_q;
    // A held B response blocks the next commit until the master takes it.
    assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axil_bready);

    assign aw_idx = addr_to_idx(64'(s_axil_awaddr), DATA_W);
    assign ar_idx = addr_to_idx(64'(s_axil_araddr), DATA_W);

    always_comb begin
        old_word = '0;
        for (int unsigned i = 0; i < N_CTRL; i++) begin
            if (aw_sel_q == CIDX_W'(i)) old_word = ctrl_q[i];
        end
    end

    axil_wstrb_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_i    (old_word),
        .new_i    (w_data_q),
        .strb_i   (w_strb_q),
        .merged_o (merged_word)
    );

    // Out-of-range indices match no entry and read as zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < N_CTRL; i++) begin
            if (ar_idx == 64'(i)) rd_word = ctrl_q[i];
        end
        for (int unsigned i = 0; i < N_STAT; i++) begin
            if (ar_idx == 64'(N_CTRL + i)) rd_word = stat_i[i*DATA_W +: DATA_W];
        end
    end

`ifdef AXIL_REG_BANK_SLVERR_EN
    assign wr_resp = aw_is_ctrl_q ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = (ar_idx < 64'(N_REGS)) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    always_comb begin
        aw_full_d    = aw_full_q;
        aw_is_ctrl_d = aw_is_ctrl_q;
        aw_sel_d     = aw_sel_q;
        w_full_d     = w_full_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        ctrl_d       = ctrl_q;
        ctrl_wr_d    = '0;

        if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
            for (int unsigned i = 0; i < N_CTRL; i++) begin
                if (aw_is_ctrl_q && aw_sel_q == CIDX_W'(i)) begin
                    ctrl_d[i]    = merged_word;
                    ctrl_wr_d[i] = 1'b1;
                end
            end
        end

        if (aw_hs) begin
            aw_full_d    = 1'b1;
            aw_is_ctrl_d = aw_idx < 64'(N_CTRL);
            aw_sel_d     = CIDX_W'(aw_idx);
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_resp;
            rdata_d  = rd_word;
        end
    end

    always_ff @(posedge Clk or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            aw_full_q    <= 1'b0;
            aw_is_ctrl_q <= 1'b0;
            aw_sel_q     <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            ctrl_wr_q    <= '0;
            for (int unsigned i = 0; i < N_CTRL; i++) begin
                ctrl_q[i] <= CTRL_RST[i*DATA_W +: DATA_W];
            end
        end else begin
            aw_full_q    <= aw_full_d;
            aw_is_ctrl_q <= aw_is_ctrl_d;
            aw_sel_q     <= aw_sel_d;
            w_full_q     <= w_full_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            ctrl_wr_q    <= ctrl_wr_d;
            ctrl_q       <= ctrl_d;
        end
    end

    for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_out
        assign ctrl_o[i*DATA_W +: DATA_W] = ctrl_q[i];
    end

    assign s_axil_awready = !aw_full_q;
    assign s_axil_wready  = !w_full_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = !rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign ctrl_wr_o      = ctrl_wr_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: vector table of write/readback pairs plus hand-written corner cases.
module tb_axil_reg_bank;

`ifdef AXIL_REG_BANK_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    localparam logic [255:0] TB_RST = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                                       32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

    logic         clk, rst;
    logic [31:0]  awaddr, wdata, araddr;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] ctrl_o, stat;
    logic [7:0]   ctrl_wr;

    int checks = 0;
    int errors = 0;

    axil_reg_bank #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .N_CTRL   (8),
        .N_STAT   (8),
        .CTRL_RST (TB_RST)
    ) dut (
        .Clk            (clk),
        .reset_rtl_0    (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .ctrl_o         (ctrl_o),
        .ctrl_wr_o      (ctrl_wr),
        .stat_i         (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AW and W presented together; lat counts negedges from handshake to bvalid.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] pulse, output int lat);
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0; resp = 2'b11; pulse = '1;
        while (!bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (bvalid) begin
            resp  = bresp;
            pulse = ctrl_wr;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rvalid && lat < 20);
        arvalid = 1'b0;
        data = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [7:0]  pulse;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [1:0]  resp;
        logic [7:0]  pulse;
        logic [31:0] rd;
        int          lat, n;

        vecs[0] = '{32'h0000_0008, 32'hDEADBEEF, 4'hF, 8'h04, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{32'h0000_000C, 32'h12345678, 4'h0, 8'h08, 32'hC0DE0003, 1'b0};
        vecs[2] = '{32'h0000_0011, 32'hAABBCCDD, 4'hA, 8'h10, 32'hAADECC04, 1'b0};
        vecs[3] = '{32'h0000_001C, 32'h00000055, 4'h1, 8'h80, 32'hC0DE0055, 1'b0};
        vecs[4] = '{32'h0000_0024, 32'hFFFFFFFF, 4'hF, 8'h00, 32'h50000001, 1'b1};
        vecs[5] = '{32'h0000_0040, 32'hFFFFFFFF, 4'hF, 8'h00, 32'h00000000, 1'b1};
        vecs[6] = '{32'h0000_0400, 32'h0F0F0F0F, 4'hF, 8'h00, 32'h00000000, 1'b1};

        rst = 1'b1;
        awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        for (int j = 0; j < 8; j++) stat[j*32 +: 32] = 32'h5000_0000 + 32'(j);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_ctrl", ctrl_o, TB_RST);
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check("rst_valid", {bvalid, rvalid}, 2'b00);
        check("rst_wr_pulse", ctrl_wr, 8'h00);
        check("rst_rdata", {rdata, bresp, rresp}, 36'h0);

        for (int v = 0; v < 7; v++) begin
            axi_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse, lat);
            check($sformatf("v%0d_wlat", v), lat, 1);
            check($sformatf("v%0d_bresp", v), resp, vecs[v].err ? ERR_RESP : 2'b00);
            check($sformatf("v%0d_pulse", v), pulse, vecs[v].pulse);
            check($sformatf("v%0d_pulse_end", v), ctrl_wr, 8'h00);
            axi_read(vecs[v].addr, rd, resp, lat);
            check($sformatf("v%0d_rlat", v), lat, 1);
            check($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
            check($sformatf("v%0d_rresp", v), resp, vecs[v].err ? ERR_RESP : 2'b00);
        end
        check("table_ctrl", ctrl_o, {32'hC0DE0055, 32'hC0DE0006, 32'hC0DE0005, 32'hAADECC04,
                                     32'hC0DE0003, 32'hDEADBEEF, 32'hC0DE0001, 32'hC0DE0000});

        // W arrives three cycles ahead of AW.
        @(negedge clk);
        wdata = 32'h0000CAFE; wstrb = 4'h3; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wfirst_ready%0d", k), {wready, awready, bvalid}, 3'b010);
            @(negedge clk);
        end
        awaddr = 32'h8; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wfirst_bvalid", bvalid, 1'b1);
        check("wfirst_pulse", ctrl_wr, 8'h04);
        check("wfirst_data", ctrl_o[64 +: 32], 32'hDEADCAFE);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // Two back-to-back writes with B stalled.
        @(negedge clk);
        awaddr = 32'h0; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awaddr = 32'h4; wdata = 32'h22222222;
        @(negedge clk);
        check("bstall_first", {bvalid, ctrl_o[31:0]}, {1'b1, 32'h11111111});
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bstall_second_taken", {awready, wready}, 2'b00);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bstall_hold%0d", k), {bvalid, bresp, ctrl_wr, ctrl_o[63:32]},
                  {1'b1, 2'b00, 8'h00, 32'hC0DE0001});
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bstall_second", {bvalid, bresp, ctrl_wr, ctrl_o[63:32]},
              {1'b1, 2'b00, 8'h02, 32'h22222222});
        @(negedge clk);
        bready = 1'b0;
        check("bstall_done", bvalid, 1'b0);

        // Status read held by rready while the source changes.
        stat[32 +: 32] = 32'h12345678;
        @(negedge clk);
        araddr = 32'h24; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        stat[32 +: 32] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rstall_hold%0d", k), {rvalid, arready, rdata}, {2'b10, 32'h12345678});
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rstall_done", {rvalid, arready}, 2'b01);

        // Read and commit on the same register at the same edge.
        @(negedge clk);
        awaddr = 32'h14; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h14; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("same_edge_rdata", {rvalid, rdata}, {1'b1, 32'hC0DE0005});
        check("same_edge_write", {bvalid, ctrl_o[160 +: 32]}, {1'b1, 32'h0BADF00D});
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        check("same_edge_done", {bvalid, rvalid}, 2'b00);

        // Reset with a B response pending.
        @(negedge clk);
        awaddr = 32'h0; wdata = 32'hFFFF0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("prerst_commit", {bvalid, ctrl_o[31:0]}, {1'b1, 32'hFFFF0000});
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", {bvalid, rvalid, awready, wready, ctrl_wr}, {4'b0011, 8'h00});
        check("midrst_ctrl", ctrl_o, TB_RST);
        rst = 1'b0;

        // A buffered W is dropped by reset; a later lone AW must not commit.
        @(negedge clk);
        wdata = 32'hBBBBBBBB; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("wbuf_full", wready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wbuf_dropped", wready, 1'b1);
        awaddr = 32'h18; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lone_aw%0d", k), {bvalid, awready, ctrl_wr}, {2'b00, 8'h00});
            @(negedge clk);
        end
        check("lone_aw_ctrl", ctrl_o, TB_RST);
        wdata = 32'h66666666; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("late_w_commit", {bvalid, ctrl_wr, ctrl_o[192 +: 32]}, {1'b1, 8'h40, 32'h66666666});
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank.
- Attaches to the AXI4-Lite master port (M01-style) of the MicroBlaze system wrapper.
- Provides N_CTRL read/write control registers and N_STAT read-only status registers.
- Generalises the fixed single-peripheral hookup: width, register counts and reset values are parameters; AW/W may arrive in any order; responses are buffered.

Parameters:
DATA_W, 32, data bus width; 32 or 64 only.
ADDR_W, 32, AXI address width.
N_CTRL, 8, number of control registers (>=1).
N_STAT, 8, number of status registers (>=0).
CTRL_RST, {N_CTRL*DATA_W{1'b0}}, flattened reset value of control registers; reg i = bits [i*DATA_W +: DATA_W].

Ports:
Clk  in  1  clock.
reset_rtl_0  in  1  reset, asynchronous, active-high.
s_axil_awaddr  in  ADDR_W  write address.
s_axil_awprot  in  3  ignored.
s_axil_awvalid/awready  in/out  1  AW handshake.
s_axil_wdata  in  DATA_W  write data.
s_axil_wstrb  in  DATA_W/8  byte enables.
s_axil_wvalid/wready  in/out  1  W handshake.
s_axil_bresp  out  2  write response.
s_axil_bvalid/bready  out/in  1  B handshake.
s_axil_araddr  in  ADDR_W  read address.
s_axil_arprot  in  3  ignored.
s_axil_arvalid/arready  in/out  1  AR handshake.
s_axil_rdata  out  DATA_W  read data.
s_axil_rresp  out  2  read response.
s_axil_rvalid/rready  out/in  1  R handshake.
ctrl_o  out  N_CTRL*DATA_W  control register contents, flattened.
ctrl_wr_o  out  N_CTRL  one-cycle pulse per register on commit.
stat_i  in  N_STAT*DATA_W  status inputs, sampled on read.

Behaviour:
- Clocking and reset: single clock Clk; reset_rtl_0 asynchronous, active-high.
- Reset values: awready=1, wready=1, arready=1; bvalid=0, rvalid=0; bresp=0, rresp=0, rdata=0; ctrl_o=CTRL_RST; ctrl_wr_o=0; both write buffers empty.
- Addressing:
  - word index = addr >> log2(DATA_W/8); low bits ignored.
  - index 0..N_CTRL-1 = ctrl; N_CTRL..N_CTRL+N_STAT-1 = stat; anything else is out of range.
- Write path:
  - Independent single-entry AW and W buffers; awready = AW buffer empty; wready = W buffer empty.
  - Commit fires in any cycle where both buffers are full and (!bvalid || bready).
  - At the commit edge: target bytes are updated per wstrb, ctrl_wr_o[idx] pulses for one cycle, both buffers are freed, and bvalid rises.
  - Best case: AW+W handshake at edge k, register updated and bvalid=1 at edge k+1.
  - Writes to stat or out-of-range addresses change nothing and produce no pulse; bresp=OKAY.
  - wstrb=0 → no data change; pulse still issued; bresp=OKAY.
  - B stall: bvalid holds until bready; no new commit is made while a response is pending and bready=0.
- Read path:
  - arready = !rvalid.
  - AR handshake at edge k → rvalid=1 with registered rdata at edge k+1; rdata/rresp held stable until rready.
  - Throughput is one read per two cycles.
  - Out-of-range reads return rdata=0, rresp=OKAY.
- Simultaneous events:
  - Read and write commit to the same register at the same edge → the read returns the pre-write value.
  - stat_i is sampled at the AR handshake edge.
- Reset mid-transaction: all buffers are dropped, all valids cleared, registers return to CTRL_RST; no response is issued for dropped transactions.

Optional Feature:
AXIL_REG_BANK_SLVERR_EN.
- Defined: out-of-range reads/writes and writes to stat registers return SLVERR (2'b10); out-of-range rdata is 0.
- Undefined: all such accesses return OKAY as specified above.
- Register contents and ctrl_wr_o behaviour are identical in both builds.

Decomposition:
- Shared package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; function addr_to_idx(addr, DATA_W).
- One natural sub-module: axil_wstrb_merge (combinational byte-enable merge of old and new word), instantiated per control register or once on the selected register.

Test Plan:
1. Reset → ctrl_o==CTRL_RST; awready=wready=arready=1; bvalid=rvalid=0.
2. Write 0xDEADBEEF to idx 2 with AW and W in the same cycle, wstrb=0xF → ctrl reg 2 updated and bvalid at +1 edge, ctrl_wr_o[2] pulses one cycle; readback = 0xDEADBEEF.
3. W three cycles before AW, wstrb=0x3, data 0x0000CAFE over 0xDEADBEEF → reg = 0xDEADCAFE; awready stays 1 until AW arrives; wready=0 while W is held.
4. Hold bready=0 for 5 cycles across two back-to-back writes → second write not committed until first B is accepted; both bresp=OKAY, in order.
5. stat_i[N_CTRL+1 idx] = 0x12345678; read addr (N_CTRL+1)*4 → rdata 0x12345678; hold rready=0 for 4 cycles while stat_i changes → rdata stays 0x12345678.
6. With SLVERR_EN: read/write addr (N_CTRL+N_STAT)*4 → rresp=bresp=2'b10, rdata=0, no ctrl change. Without SLVERR_EN: OKAY. Assert reset_rtl_0 mid-write → bvalid=0 next cycle, ctrl_o==CTRL_RST.
